// File: rtl/i2c_types_pkg.sv
// Shared I2C types for the responder and bus monitors.
// FSM state encoding and ACK/NACK bit levels.
package i2c_types_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_FETCH,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } i2c_slv_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  function automatic logic addr_hit(
    input logic [7:0] b,
    input logic [6:0] a
  );
    return b[7:1] == a;
  endfunction

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus pins and local sink/source handshake of the I2C responder.
// slave = responder side, master = environment side.
interface i2c_slave_responder_if;

  logic       scl_i;
  logic       sda_i;
  logic       scl_oe_o;
  logic       sda_oe_o;
  logic [7:0] wr_data_o;
  logic       wr_valid_o;
  logic       rd_req_o;
  logic [7:0] rd_data_i;
  logic       rd_valid_i;
  logic       start_o;
  logic       stop_o;
  logic       busy_o;
  logic       rw_o;
  logic       nack_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i, rd_valid_i,
    output scl_oe_o, sda_oe_o, wr_data_o, wr_valid_o,
    output rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i, rd_valid_i,
    input  scl_oe_o, sda_oe_o, wr_data_o, wr_valid_o,
    input  rd_req_o, start_o, stop_o, busy_o, rw_o, nack_o
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with edge, START and STOP detection.
// Idle-bus reset value keeps spurious events out after reset.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_sync,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_d;
  logic                   sda_d;

  // synchronizer chains plus one delayed copy for edge detect
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
      scl_d  <= scl_sync;
      sda_d  <= sda_sync;
    end
  end

  assign scl_sync  = scl_ff[SYNC_STAGES-1];
  assign sda_sync  = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_sync & ~scl_d;
  assign scl_fall  = ~scl_sync & scl_d;
  assign start_det = scl_sync & scl_d & sda_d & ~sda_sync;
  assign stop_det  = scl_sync & scl_d & ~sda_d & sda_sync;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, write sink, read source with
// SCL stretching. All bus drives come straight from flops.
module i2c_slave_responder
  import i2c_types_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = 7'h22,
  parameter int         SYNC_STAGES = 2,
  parameter bit         STRETCH_EN  = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_n,
  i2c_slave_responder_if.slave bus
);

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_slv_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       ack_q, ack_d;
  logic       have_q, have_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       rd_req_q, rd_req_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;

  logic [7:0] byte_in;
  logic [7:0] rd_byte;
  logic       accept;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .scl_i    (bus.scl_i),
    .sda_i    (bus.sda_i),
    .scl_sync (scl_s),
    .sda_sync (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign byte_in = {sh_q[6:0], sda_s};
  assign accept  = rd_req_q & bus.rd_valid_i;

  // next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    ack_d      = ack_q;
    have_d     = have_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = rd_req_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    nack_d     = 1'b0;
    rd_byte    = have_q ? sh_q : 8'hFF;
    if (accept) rd_byte = bus.rd_data_i;

    if (stop_det) begin
      stop_d   = 1'b1;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b0;
      rd_req_d = 1'b0;
      ack_d    = 1'b0;
      have_d   = 1'b0;
      state_d  = IDLE;
    end else if (start_det) begin
      start_d  = 1'b1;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      rd_req_d = 1'b0;
      ack_d    = 1'b0;
      have_d   = 1'b0;
      cnt_d    = 3'd0;
      state_d  = ADDR;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        ADDR: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (addr_hit(byte_in, SLV_ADDR)) begin
                state_d = ADDR_ACK;
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d    = 1'b1;
              sda_oe_d = ~I2C_ACK;
            end else begin
              ack_d    = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              if (state_q == WR_ACK || !rw_q) begin
                state_d = WR_BYTE;
              end else begin
                state_d  = RD_FETCH;
                rd_req_d = 1'b1;
                have_d   = 1'b0;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              wr_data_d  = byte_in;
              wr_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        RD_FETCH: begin
          if (accept) begin
            rd_req_d = 1'b0;
            have_d   = 1'b1;
            sh_d     = bus.rd_data_i;
          end
          // only commit a bit to SDA while SCL is low
          if (!scl_s) begin
            if (accept || have_q || !STRETCH_EN) begin
              sh_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              scl_oe_d = 1'b0;
              rd_req_d = 1'b0;
              have_d   = 1'b0;
              cnt_d    = 3'd0;
              state_d  = RD_BYTE;
            end else begin
              scl_oe_d = 1'b1;
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) cnt_d = cnt_q + 3'd1;
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              state_d  = RD_FETCH;
              rd_req_d = 1'b1;
            end else begin
              nack_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        IGNORE: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and registered outputs; reset releases both lines
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sh_q       <= 8'd0;
      ack_q      <= 1'b0;
      have_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      wr_data_q  <= 8'd0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      ack_q      <= ack_d;
      have_q     <= have_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
    end
  end

  assign bus.scl_oe_o   = scl_oe_q;
  assign bus.sda_oe_o   = sda_oe_q;
  assign bus.wr_data_o  = wr_data_q;
  assign bus.wr_valid_o = wr_valid_q;
  assign bus.rd_req_o   = rd_req_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.busy_o     = busy_q;
  assign bus.rw_o       = rw_q;
  assign bus.nack_o     = nack_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master,
// byte source with programmable delay, scoreboard queues.
module tb_i2c_slave_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  int n_start = 0;
  int n_stop  = 0;
  int n_nack  = 0;
  int str_cur = 0;
  int str_max = 0;
  int viol    = 0;
  logic sda_oe_prev = 1'b0;
  logic scl_prev = 1'b1;

  logic [7:0] wr_exp_q[$];
  logic [7:0] wr_obs_q[$];
  logic [7:0] rd_exp_q[$];
  logic [7:0] src_q[$];
  int src_delay = 0;
  int src_cnt = 0;

  localparam int Q = 10;

  i2c_slave_responder_if bus_if ();

  assign bus_if.scl_i = m_scl & ~bus_if.scl_oe_o;
  assign bus_if.sda_i = m_sda & ~bus_if.sda_oe_o;

  i2c_slave_responder #(
    .SLV_ADDR   (7'h22),
    .SYNC_STAGES(2),
    .STRETCH_EN (1'b1)
  ) dut (
    .clk_i(clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: sim time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bus_if.wr_valid_o) wr_obs_q.push_back(bus_if.wr_data_o);
    if (bus_if.start_o) n_start++;
    if (bus_if.stop_o) n_stop++;
    if (bus_if.nack_o) n_nack++;
    if (bus_if.scl_oe_o) str_cur++;
    else str_cur = 0;
    if (str_cur > str_max) str_max = str_cur;
    if (rst_n && bus_if.sda_oe_o !== sda_oe_prev
        && scl_prev && bus_if.scl_i) viol++;
    sda_oe_prev = bus_if.sda_oe_o;
    scl_prev = bus_if.scl_i;
  end

  initial begin
    bus_if.rd_valid_i = 1'b0;
    bus_if.rd_data_i = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_if.rd_valid_i = 1'b0;
        src_cnt = 0;
      end else if (bus_if.rd_valid_i) begin
        if (!bus_if.rd_req_o) begin
          bus_if.rd_valid_i = 1'b0;
          void'(src_q.pop_front());
          src_cnt = 0;
        end
      end else if (bus_if.rd_req_o && src_q.size() > 0) begin
        if (src_cnt >= src_delay) begin
          bus_if.rd_data_i = src_q[0];
          bus_if.rd_valid_i = 1'b1;
        end else begin
          src_cnt++;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int t = 0;
    #1;
    while (bus_if.scl_i !== 1'b1 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL scl_release: low %0d cycles, required high", t);
    end
  endtask

  task automatic send_start();
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_cycles(Q);
    m_sda = 1'b0;
    wait_cycles(Q);
    m_scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic send_rstart();
    m_sda = 1'b1;
    wait_cycles(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_cycles(Q);
    m_sda = 1'b0;
    wait_cycles(Q);
    m_scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic send_stop();
    m_sda = 1'b0;
    wait_cycles(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_cycles(Q);
    m_sda = 1'b1;
    wait_cycles(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    wait_cycles(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_cycles(2 * Q);
    m_scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1;
    wait_cycles(Q);
    m_scl = 1'b1;
    wait_scl_high();
    wait_cycles(Q);
    b = bus_if.sda_i;
    wait_cycles(Q);
    m_scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_cycles(5);
    n_tests++;
    if ({bus_if.scl_oe_o, bus_if.sda_oe_o, bus_if.wr_valid_o,
         bus_if.rd_req_o, bus_if.start_o, bus_if.stop_o,
         bus_if.busy_o, bus_if.rw_o, bus_if.nack_o} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got non-zero controls, required 0");
    end
    n_tests++;
    if (bus_if.wr_data_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_wr_data: got %h required 00",
               bus_if.wr_data_o);
    end
    rst_n = 1'b1;
    wait_cycles(10);
    n_tests++;
    if (bus_if.start_o !== 1'b0 || bus_if.busy_o !== 1'b0
        || n_start != 0) begin
      n_fail++;
      $display("FAIL post_reset: start=%b busy=%b starts=%0d, required 0",
               bus_if.start_o, bus_if.busy_o, n_start);
    end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] exp_b;
    logic [7:0] obs_b;
    logic [7:0] wb[2];
    wb[0] = 8'hA5;
    wb[1] = 8'h3C;
    wr_obs_q.delete();
    wr_exp_q.delete();
    n_stop = 0;
    send_start();
    send_byte(8'h44, ack);
    n_tests++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_addr_ack: got %b required 0", ack);
    end
    n_tests++;
    if (bus_if.busy_o !== 1'b1 || bus_if.rw_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_busy_rw: got busy=%b rw=%b required 1 0",
               bus_if.busy_o, bus_if.rw_o);
    end
    for (int i = 0; i < 2; i++) begin
      wr_exp_q.push_back(wb[i]);
      send_byte(wb[i], ack);
      n_tests++;
      if (ack !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_data_ack%0d: got %b required 0", i, ack);
      end
    end
    send_stop();
    wait_cycles(4);
    n_tests++;
    if (wr_obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL wr_count: got %0d required 2", wr_obs_q.size());
    end
    while (wr_exp_q.size() > 0 && wr_obs_q.size() > 0) begin
      exp_b = wr_exp_q.pop_front();
      obs_b = wr_obs_q.pop_front();
      n_tests++;
      if (obs_b !== exp_b) begin
        n_fail++;
        $display("FAIL wr_byte: got %h required %h", obs_b, exp_b);
      end
    end
    n_tests++;
    if (n_stop != 1 || bus_if.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_stop: got stops=%0d busy=%b required 1 0",
               n_stop, bus_if.busy_o);
    end
  endtask

  task automatic test_nomatch();
    logic ack;
    wr_obs_q.delete();
    n_stop = 0;
    send_start();
    send_byte(8'h46, ack);
    n_tests++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL nm_addr_ack: got %b required 1", ack);
    end
    n_tests++;
    if (bus_if.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nm_busy: got %b required 0", bus_if.busy_o);
    end
    send_byte(8'h55, ack);
    n_tests++;
    if (ack !== 1'b1 || wr_obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL nm_ignore: got ack=%b wr=%0d required 1 0",
               ack, wr_obs_q.size());
    end
    send_stop();
    wait_cycles(4);
    n_tests++;
    if (n_stop != 1) begin
      n_fail++;
      $display("FAIL nm_stop: got %0d required 1", n_stop);
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_b;
    src_delay = 0;
    src_q.delete();
    rd_exp_q.delete();
    src_q.push_back(8'h5A);
    rd_exp_q.push_back(8'h5A);
    src_q.push_back(8'hC3);
    rd_exp_q.push_back(8'hC3);
    n_nack = 0;
    viol = 0;
    send_start();
    send_byte(8'h45, ack);
    n_tests++;
    if (ack !== 1'b0 || bus_if.rw_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_addr: got ack=%b rw=%b required 0 1",
               ack, bus_if.rw_o);
    end
    recv_byte(d, 1'b0);
    exp_b = rd_exp_q.pop_front();
    n_tests++;
    if (d !== exp_b) begin
      n_fail++;
      $display("FAIL rd_byte0: got %b required %b", d, exp_b);
    end
    recv_byte(d, 1'b1);
    exp_b = rd_exp_q.pop_front();
    n_tests++;
    if (d !== exp_b) begin
      n_fail++;
      $display("FAIL rd_byte1: got %b required %b", d, exp_b);
    end
    n_tests++;
    if (n_nack != 1 || bus_if.sda_oe_o !== 1'b0
        || bus_if.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_nack: got nacks=%0d sda_oe=%b busy=%b req 1 0 0",
               n_nack, bus_if.sda_oe_o, bus_if.busy_o);
    end
    send_stop();
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL rd_sda_stable: got %0d changes with SCL high, req 0",
               viol);
    end
  endtask

  task automatic test_stretch();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_b;
    src_delay = 200;
    src_q.delete();
    rd_exp_q.delete();
    src_q.push_back(8'h81);
    rd_exp_q.push_back(8'h81);
    send_start();
    send_byte(8'h45, ack);
    str_max = 0;
    recv_byte(d, 1'b1);
    exp_b = rd_exp_q.pop_front();
    n_tests++;
    if (d !== exp_b) begin
      n_fail++;
      $display("FAIL st_byte: got %h required %h", d, exp_b);
    end
    n_tests++;
    if (str_max < 200) begin
      n_fail++;
      $display("FAIL st_len: got %0d cycles required >=200", str_max);
    end
    n_tests++;
    if (bus_if.scl_oe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL st_release: got %b required 0", bus_if.scl_oe_o);
    end
    send_stop();
    src_delay = 0;
  endtask

  task automatic test_back_to_back();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp_b;
    logic [7:0] obs_b;
    wr_obs_q.delete();
    wr_exp_q.delete();
    rd_exp_q.delete();
    src_q.delete();
    n_start = 0;
    n_stop = 0;
    send_start();
    send_byte(8'h44, ack);
    n_tests++;
    if (ack !== 1'b0 || bus_if.rw_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rs_wr_addr: got ack=%b rw=%b required 0 0",
               ack, bus_if.rw_o);
    end
    wr_exp_q.push_back(8'h11);
    send_byte(8'h11, ack);
    send_rstart();
    send_byte(8'h45, ack);
    n_tests++;
    if (ack !== 1'b0 || bus_if.rw_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rs_rd_addr: got ack=%b rw=%b required 0 1",
               ack, bus_if.rw_o);
    end
    src_q.push_back(8'h96);
    rd_exp_q.push_back(8'h96);
    recv_byte(d, 1'b1);
    exp_b = rd_exp_q.pop_front();
    n_tests++;
    if (d !== exp_b) begin
      n_fail++;
      $display("FAIL rs_rd_byte: got %h required %h", d, exp_b);
    end
    exp_b = wr_exp_q.pop_front();
    obs_b = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 8'hxx;
    n_tests++;
    if (obs_b !== exp_b) begin
      n_fail++;
      $display("FAIL rs_wr_byte: got %h required %h", obs_b, exp_b);
    end
    n_tests++;
    if (n_start != 2 || n_stop != 0) begin
      n_fail++;
      $display("FAIL rs_events: got starts=%0d stops=%0d required 2 0",
               n_start, n_stop);
    end
    send_stop();
  endtask

  task automatic test_reset_midread();
    logic ack;
    logic b;
    logic [2:0] bits;
    logic [7:0] exp_b;
    logic [7:0] obs_b;
    src_delay = 0;
    src_q.delete();
    src_q.push_back(8'h00);
    send_start();
    send_byte(8'h45, ack);
    for (int i = 0; i < 3; i++) begin
      recv_bit(b);
      bits[i] = b;
    end
    n_tests++;
    if (bits !== 3'b000 || bus_if.sda_oe_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got bits=%b sda_oe=%b required 000 1",
               bits, bus_if.sda_oe_o);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_if.sda_oe_o !== 1'b0 || bus_if.scl_oe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got sda_oe=%b scl_oe=%b required 0 0",
               bus_if.sda_oe_o, bus_if.scl_oe_o);
    end
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    src_q.delete();
    wait_cycles(10);
    n_tests++;
    if (bus_if.busy_o !== 1'b0 || bus_if.rd_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: got busy=%b rd_req=%b required 0 0",
               bus_if.busy_o, bus_if.rd_req_o);
    end
    wr_obs_q.delete();
    wr_exp_q.delete();
    send_start();
    send_byte(8'h44, ack);
    wr_exp_q.push_back(8'h77);
    send_byte(8'h77, ack);
    n_tests++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_next_ack: got %b required 0", ack);
    end
    send_stop();
    exp_b = wr_exp_q.pop_front();
    obs_b = (wr_obs_q.size() > 0) ? wr_obs_q.pop_front() : 8'hxx;
    n_tests++;
    if (obs_b !== exp_b) begin
      n_fail++;
      $display("FAIL rst_next_byte: got %h required %h", obs_b, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_nomatch();
    test_read();
    test_stretch();
    test_back_to_back();
    test_reset_midread();
    wait_cycles(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) for the far end of the I2CMB master bus.
- Decodes START, STOP and repeated START, matches a 7-bit address, ACKs, and delivers write bytes to a local sink.
- Fetches read bytes from a local source and stretches SCL while read data is not ready.
- Used as on-die loopback target and as emulation partner for the i2cmb environment.

Parameters:
- SLV_ADDR, 7'h22, 7-bit address answered.
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizers (min 2).
- STRETCH_EN, 1, 1 = hold SCL low while awaiting read data; 0 = send 8'hFF if data is not ready.

Ports:
- clk_i  in  1  system clock; must be at least 16x the SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  bus SCL sense.
- sda_i  in  1  bus SDA sense.
- scl_oe_o  out  1  1 = pull SCL low (open-drain).
- sda_oe_o  out  1  1 = pull SDA low (open-drain).
- wr_data_o  out  8  received write byte.
- wr_valid_o  out  1  one-cycle strobe; wr_data_o is valid while it is high.
- rd_req_o  out  1  level; high while a read byte is needed.
- rd_data_i  in  8  read byte from the source.
- rd_valid_i  in  1  source handshake; a byte is accepted when rd_req_o and rd_valid_i are both high.
- start_o  out  1  one-cycle strobe on START or repeated START.
- stop_o  out  1  one-cycle strobe on STOP.
- busy_o  out  1  high from address match until STOP or NACK-end.
- rw_o  out  1  R/W bit of the current transfer; 1 = read.
- nack_o  out  1  one-cycle strobe when the master NACKs a read byte.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, bit counter 0, shift register 0.
- Synchronizers reset to 1 (idle bus).
- Edge detect runs on the synchronized signals:
  - SCL rise = sample point; SCL fall = drive-update point.
  - Event latency from pin to strobe: SYNC_STAGES+1 cycles.
- START: SDA falls while SCL is high. It is recognized in any state, including mid-byte (repeated START).
  - Pulse start_o, release SDA, clear the bit counter, go to ADDR.
- STOP: SDA rises while SCL is high. Recognized in any state.
  - Pulse stop_o, release SCL/SDA, clear busy_o, go to IDLE.
  - If START and STOP are detected in the same cycle, STOP wins.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_FETCH, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift 8 bits MSB first on SCL rise.
  - After bit 8: if [7:1]==SLV_ADDR, go to ADDR_ACK with rw_o=bit0 and busy_o=1; else go to IGNORE.
- ADDR_ACK: on the next SCL fall, assert sda_oe_o; hold it through the ACK high phase; release it on the following SCL fall.
  - Then go to WR_BYTE if rw_o=0, or RD_FETCH if rw_o=1.
- WR_BYTE: shift 8 bits, then go to WR_ACK.
  - wr_valid_o pulses one cycle after the 8th SCL rise; wr_data_o holds until the next strobe.
  - Every write byte is ACKed. There is no backpressure on the sink.
- RD_FETCH: rd_req_o=1.
  - STRETCH_EN=1: scl_oe_o is asserted from the first cycle SCL is seen low until the accept handshake; it is released the cycle after acceptance. Wait for rd_valid_i, then load the shift register and go to RD_BYTE.
  - STRETCH_EN=0: if rd_valid_i is not high at SCL fall, load 8'hFF.
- RD_BYTE: drive bit7 first.
  - Each bit is set on SCL fall: sda_oe_o = ~bit, so a 1 bit releases SDA.
  - SDA is never changed while SCL is high.
  - After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on SCL rise.
  - SDA=0: go to RD_FETCH.
  - SDA=1: pulse nack_o, clear busy_o, go to IGNORE.
- IGNORE: SDA and SCL released; only START or STOP leave this state.
- Bit counter is 3-bit and wraps at 8; a 9th-bit ACK phase is tracked by state, not by the counter.
- Async reset mid-transfer releases both lines immediately, with no glitch-low.

Decomposition:
- i2c_types_pkg additions:
  - enum i2c_slv_state_t for the FSM states.
  - constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
- Sub-module i2c_bus_sync: SYNC_STAGES synchronizer plus edge/START/STOP detection. Outputs scl_rise, scl_fall, start_det, stop_det and the synced SDA.
  - Reused by the planned arbitration monitor.

Test Plan:
- Write to 0x22 with bytes A5,3C then STOP -> address ACK, two wr_valid_o strobes with A5 then 3C, each byte ACKed, stop_o pulses, busy_o=0.
- Address 0x23 write -> no ACK (SDA high on 9th clock), no wr_valid_o, IGNORE until STOP.
- Read from 0x22, source supplies 5A then C3, master ACKs then NACKs -> bus bits 01011010 then 11000011, nack_o pulses once, SDA released.
- Read with STRETCH_EN=1 and rd_valid_i delayed 200 clk -> SCL held low 200+ cycles, then released; byte 0x81 transmitted intact.
- Write 0x11, then repeated START, then read, to 0x22 -> start_o pulses twice, rw_o goes 0 then 1, read data correct with no intervening STOP.
- rst_n asserted mid-read with SDA held low -> sda_oe_o and scl_oe_o drop to 0 that cycle; after release the FSM is in IDLE and the next transfer succeeds.
